// File: rtl/goertzel_pkg.sv
// Shared types and constants for the single-bin Goertzel detector.
// Holds the finalization state encoding and the power clamp helper.
package goertzel_pkg;

    localparam int COEFF_W = 18;
    localparam int ACC_W   = 67;
    localparam int POWER_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SQ1,
        SQ2,
        CR1,
        CR2,
        OUT
    } state_t;

    // Negative accumulators come from truncation in the cross term, so floor them at zero.
    function automatic logic [POWER_W-1:0] clamp_power(input logic signed [ACC_W-1:0] acc);
        if (acc[ACC_W-1]) begin
            return '0;
        end else if (|acc[ACC_W-2:POWER_W]) begin
            return '1;
        end else begin
            return acc[POWER_W-1:0];
        end
    endfunction

endpackage

// File: rtl/goertzel_power_calc.sv
// Turns a completed block's (f1, f2) snapshot into bin power using one shared multiplier,
// sequenced over four states: f1^2, +f2^2, m = coeff*f1, -m*f2.
module goertzel_power_calc
    import goertzel_pkg::*;
#(
    parameter logic signed [COEFF_W-1:0] COEFF      = '0,
    parameter int                        COEFF_FRAC = 14,
    parameter int                        STATE_W    = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic signed [STATE_W-1:0] f1_in,
    input  logic signed [STATE_W-1:0] f2_in,
    output logic [POWER_W-1:0]        power_out,
    output logic                      power_valid_out,
    output logic                      busy_out
);

    // Wide enough for either a raw state value or the rescaled cross term m.
    localparam int MUL_W = STATE_W + COEFF_W - COEFF_FRAC;

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [MUL_W-1:0]   m;
    logic signed [MUL_W-1:0]   mul_a;
    logic signed [MUL_W-1:0]   mul_b;
    logic signed [2*MUL_W-1:0] mul_p;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mul_a = MUL_W'(f1_in);
        mul_b = MUL_W'(f1_in);
        case (state)
            SQ2: begin
                mul_a = MUL_W'(f2_in);
                mul_b = MUL_W'(f2_in);
            end
            CR1: begin
                mul_a = MUL_W'(COEFF);
                mul_b = MUL_W'(f1_in);
            end
            CR2: begin
                mul_a = m;
                mul_b = MUL_W'(f2_in);
            end
            default: ;
        endcase
        mul_p = mul_a * mul_b;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= IDLE;
            acc             <= '0;
            m               <= '0;
            power_out       <= '0;
            power_valid_out <= 1'b0;
            busy_out        <= 1'b0;
        end else begin
            power_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        state    <= SQ1;
                        busy_out <= 1'b1;
                    end
                end
                SQ1: begin
                    acc   <= ACC_W'(mul_p);
                    state <= SQ2;
                end
                SQ2: begin
                    acc   <= acc + ACC_W'(mul_p);
                    state <= CR1;
                end
                CR1: begin
                    m     <= MUL_W'(mul_p >>> COEFF_FRAC);
                    state <= CR2;
                end
                CR2: begin
                    acc   <= acc - ACC_W'(mul_p);
                    state <= OUT;
                end
                OUT: begin
                    power_out       <= clamp_power(acc);
                    power_valid_out <= 1'b1;
                    busy_out        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/goertzel_bin.sv
// Single-bin Goertzel detector: runs the recurrence over N_SAMPLES-sample blocks and
// hands each block's final state to the power stage while the next block starts at once.
module goertzel_bin
    import goertzel_pkg::*;
#(
    parameter int                        N_SAMPLES  = 256,
    parameter logic signed [COEFF_W-1:0] COEFF      = '0,
    parameter int                        COEFF_FRAC = 14,
    parameter int                        STATE_W    = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               sample_valid_in,
    input  logic [7:0]         sample_in,
    input  logic               clear_in,
    output logic [POWER_W-1:0] power_out,
    output logic               power_valid_out,
    output logic               busy_out
);

    localparam int CNT_W = $clog2(N_SAMPLES);

    logic signed [STATE_W-1:0]         s1;
    logic signed [STATE_W-1:0]         s2;
    logic signed [STATE_W-1:0]         f1;
    logic signed [STATE_W-1:0]         f2;
    logic signed [STATE_W-1:0]         x_ext;
    logic signed [STATE_W-1:0]         rec_term;
    logic signed [STATE_W-1:0]         s_new;
    logic signed [COEFF_W+STATE_W-1:0] rec_prod;
    logic [CNT_W-1:0]                  count;
    logic                              last_sample;
    logic                              snap;

    assign x_ext       = {{(STATE_W-8){sample_in[7]}}, sample_in};
    assign rec_prod    = COEFF * s1;
    assign rec_term    = STATE_W'(rec_prod >>> COEFF_FRAC);
    assign s_new       = x_ext + rec_term - s2;
    assign last_sample = (count == CNT_W'(N_SAMPLES - 1));
    // Clear wins over a coincident strobe, so a cleared sample can never complete a block.
    assign snap        = sample_valid_in && !clear_in && last_sample;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the async reset covers all state here; there is no memory array to leave unreset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1    <= '0;
            s2    <= '0;
            f1    <= '0;
            f2    <= '0;
            count <= '0;
        end else if (clear_in) begin
            s1    <= '0;
            s2    <= '0;
            count <= '0;
        end else if (sample_valid_in) begin
            if (last_sample) begin
                f1    <= s_new;
                f2    <= s1;
                s1    <= '0;
                s2    <= '0;
                count <= '0;
            end else begin
                s2    <= s1;
                s1    <= s_new;
                count <= count + 1'b1;
            end
        end
    end

    goertzel_power_calc #(
        .COEFF      (COEFF),
        .COEFF_FRAC (COEFF_FRAC),
        .STATE_W    (STATE_W)
    ) u_power_calc (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (snap),
        .f1_in           (f1),
        .f2_in           (f2),
        .power_out       (power_out),
        .power_valid_out (power_valid_out),
        .busy_out        (busy_out)
    );

endmodule

// File: tb/tb_goertzel_bin.sv
// Scoreboard bench for goertzel_bin at N_SAMPLES=16, COEFF=0 (bin fs/4): stimulus pushes the
// hand-computed power and pulse cycle for each block, a monitor pops on every valid pulse.
module tb_goertzel_bin;

    typedef struct {
        logic [63:0] power;
        int          cyc;
    } exp_t;

    logic        clk_in;
    logic        rst_in;
    logic        sample_valid_in;
    logic [7:0]  sample_in;
    logic        clear_in;
    logic [63:0] power_out;
    logic        power_valid_out;
    logic        busy_out;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;
    logic check_busy;

    goertzel_bin #(
        .N_SAMPLES  (16),
        .COEFF      (18'sd0),
        .COEFF_FRAC (14),
        .STATE_W    (32)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .clear_in        (clear_in),
        .power_out       (power_out),
        .power_valid_out (power_valid_out),
        .busy_out        (busy_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each pulse, and in the max-rate phase checks busy_out.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (power_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("power", power_out, e.power);
                    check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (check_busy) begin
                logic busy_exp;
                busy_exp = 1'b0;
                if (exp_q.size() > 0)
                    busy_exp = (cyc >= exp_q[0].cyc - 5) && (cyc <= exp_q[0].cyc - 1);
                check("busy", 64'(busy_out), 64'(busy_exp));
            end
        end
    end

    function automatic logic [7:0] pat2(input int i);
        case (i % 4)
            0:       return 8'd64;
            2:       return 8'hC0;
            default: return 8'd0;
        endcase
    endfunction

    // Inputs change 1 time unit after a rising edge; the next edge captures them.
    task automatic strobe(input logic [7:0] x, input logic clr, input logic last,
                          input logic expect_pulse, input logic [63:0] power, input int gap);
        exp_t e;
        sample_valid_in = 1'b1;
        sample_in       = x;
        clear_in        = clr;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        clear_in        = 1'b0;
        if (last && expect_pulse) begin
            e.power = power;
            e.cyc   = cyc + 5;
            exp_q.push_back(e);
        end
        repeat (gap) @(posedge clk_in);
        if (gap > 0) #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        check_busy      = 1'b0;
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        sample_in       = 8'd0;
        clear_in        = 1'b0;
        #12;
        check("reset_power", power_out, 64'd0);
        check("reset_valid", 64'(power_valid_out), 64'd0);
        check("reset_busy", 64'(busy_out), 64'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        idle(2);

        // 1: all zeros
        for (int i = 0; i < 16; i++) strobe(8'd0, 1'b0, i == 15, 1'b1, 64'd0, 1);
        idle(8);

        // 2: 64,0,-64,0 -> f1=0, f2=-512
        for (int i = 0; i < 16; i++) strobe(pat2(i), 1'b0, i == 15, 1'b1, 64'd262144, 2);
        idle(8);

        // 3: DC rejected, then on-bin block back-to-back
        for (int i = 0; i < 16; i++) strobe(8'd64, 1'b0, i == 15, 1'b1, 64'd0, 0);
        for (int i = 0; i < 16; i++) strobe(pat2(i), 1'b0, i == 15, 1'b1, 64'd262144, 0);
        idle(8);

        // 5 then zeros then 3 -> f1=3, f2=-5 -> 34; a clear right after must not abort the pulse
        for (int i = 0; i < 16; i++)
            strobe((i == 0) ? 8'd5 : ((i == 15) ? 8'd3 : 8'd0), 1'b0, i == 15, 1'b1, 64'd34, 0);
        clear_in = 1'b1;
        idle(1);
        clear_in = 1'b0;
        idle(8);

        // 4: clear with strobe on sample 5, then a clean block
        for (int i = 0; i < 4; i++) strobe(8'd100, 1'b0, 1'b0, 1'b0, 64'd0, 0);
        strobe(8'd77, 1'b1, 1'b0, 1'b0, 64'd0, 0);
        for (int i = 0; i < 16; i++) strobe(pat2(i), 1'b0, i == 15, 1'b1, 64'd262144, 0);
        idle(8);

        // 5: reset while finalization sits in CR1
        for (int i = 0; i < 16; i++) strobe(pat2(i), 1'b0, 1'b0, 1'b0, 64'd0, 0);
        @(posedge clk_in);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check("rst_cr1_power", power_out, 64'd0);
        check("rst_cr1_valid", 64'(power_valid_out), 64'd0);
        check("rst_cr1_busy", 64'(busy_out), 64'd0);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        idle(10);
        for (int i = 0; i < 16; i++) strobe(pat2(i), 1'b0, i == 15, 1'b1, 64'd262144, 0);
        idle(8);

        // 6: max rate, three blocks
        check_busy = 1'b1;
        for (int i = 0; i < 48; i++) strobe(pat2(i), 1'b0, (i % 16) == 15, 1'b1, 64'd262144, 0);

        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(posedge clk_in);
        idle(2);
        check_busy = 1'b0;
        check("pending_pulses", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
